// File: rtl/pp_resize_pkg.sv
// Shared types and default widths for the resize coordinate generator.
package pp_resize_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int FRAC_W_DEF  = 9;

    typedef enum logic [2:0] {
        IDLE,
        ROW_Y,
        ROW_WAIT,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic is_y;
        logic eol;
        logic eof;
    } tag_t;

endpackage

// File: rtl/pp_coord_split.sv
// Splits a coord*scale product into integer source index and fraction.
// PP_COORD_CLAMP_EN adds a clamp of the index to bound-1 (fraction zeroed when clamped).
module pp_coord_split
    import pp_resize_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic [2*COORD_W-1:0] prod,
    input  logic [COORD_W-1:0]   bound,
    output logic [COORD_W-1:0]   int_part,
    output logic [FRAC_W-1:0]    frac_part
);

    logic [COORD_W-1:0] raw_int;
    logic               unused_hi;

    assign raw_int   = prod[FRAC_W +: COORD_W];
    assign unused_hi = ^prod[2*COORD_W-1:FRAC_W+COORD_W];

`ifdef PP_COORD_CLAMP_EN
    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    function automatic logic [COORD_W-1:0] sat_to_limit(input logic [COORD_W-1:0] v,
                                                        input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [COORD_W-1:0] lim;

    assign lim       = bound - ONE;
    assign int_part  = sat_to_limit(raw_int, lim);
    assign frac_part = (raw_int > lim) ? '0 : prod[FRAC_W-1:0];
`else
    logic unused_bound;

    assign unused_bound = ^bound;
    assign int_part     = raw_int;
    assign frac_part    = prod[FRAC_W-1:0];
`endif

endmodule

// File: rtl/pp_resize_coord_gen.sv
// Raster walker feeding an external 2-cycle multiplier; emits {src_x,src_y,frac_x,frac_y} per pixel.
// Optional index clamp selected by PP_COORD_CLAMP_EN (see pp_coord_split).
module pp_resize_coord_gen
    import pp_resize_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic                   start,
    input  logic [COORD_W-1:0]     cfg_out_w,
    input  logic [COORD_W-1:0]     cfg_out_h,
    input  logic [COORD_W-1:0]     cfg_in_w,
    input  logic [COORD_W-1:0]     cfg_in_h,
    input  logic [COORD_W-1:0]     cfg_scl_x,
    input  logic [COORD_W-1:0]     cfg_scl_y,
    output logic                   mul_ce,
    output logic [COORD_W-1:0]     mul_din0,
    output logic [COORD_W-1:0]     mul_din1,
    input  logic [2*COORD_W-1:0]   mul_dout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COORD_W-1:0]     out_src_x,
    output logic [COORD_W-1:0]     out_src_y,
    output logic [FRAC_W-1:0]      out_frac_x,
    output logic [FRAC_W-1:0]      out_frac_y,
    output logic                   out_eol,
    output logic                   out_eof,
    output logic                   busy
);

    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    state_t             state, state_nxt;
    logic [COORD_W-1:0] out_w_r, out_h_r, in_w_r, in_h_r, scl_x_r, scl_y_r;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic               vld_p0, vld_p1, vld_p2;
    tag_t               tag_iss, tag_p0, tag_p1, tag_p2;
    logic [COORD_W-1:0] src_y_r;
    logic [FRAC_W-1:0]  frac_y_r;
    logic [COORD_W-1:0] x_int, y_int;
    logic [FRAC_W-1:0]  x_frac, y_frac;
    logic               last_x, last_y, iss_x, iss_y, eof_hs;

    assign mul_ce = !(out_valid && !out_ready);
    assign last_x = (x_cnt == out_w_r - ONE);
    assign last_y = (y_cnt == out_h_r - ONE);
    assign iss_y  = mul_ce && (state == ROW_Y);
    assign iss_x  = mul_ce && (state == RUN);
    assign eof_hs = out_valid && out_ready && out_eof;

    always_comb begin
        tag_iss      = '0;
        tag_iss.is_y = iss_y;
        tag_iss.eol  = iss_x && last_x;
        tag_iss.eof  = iss_x && last_x && last_y;
    end

    // Leave ROW_WAIT as the row's y product moves into the split stage, so x0 issues
    // on the edge that latches src_y (3-cycle row-start bubble).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ROW_Y;
            ROW_Y:    if (mul_ce) state_nxt = ROW_WAIT;
            ROW_WAIT: if (mul_ce && vld_p1 && tag_p1.is_y) state_nxt = RUN;
            RUN:      if (mul_ce && last_x) state_nxt = last_y ? DRAIN : ROW_Y;
            DRAIN:    if (eof_hs) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            mul_din0  <= '0;
            mul_din1  <= '0;
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            tag_p0    <= '0;
            tag_p1    <= '0;
            tag_p2    <= '0;
            out_valid <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                busy  <= 1'b1;
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (state == DRAIN && eof_hs) begin
                busy <= 1'b0;
            end
            if (iss_y) begin
                mul_din0 <= y_cnt;
                mul_din1 <= scl_y_r;
            end
            if (iss_x) begin
                mul_din0 <= x_cnt;
                mul_din1 <= scl_x_r;
                x_cnt    <= last_x ? '0 : x_cnt + ONE;
                if (last_x && !last_y) y_cnt <= y_cnt + ONE;
            end
            // p0 rides with din, p2 lines up with mul_dout
            if (mul_ce) begin
                vld_p0    <= iss_x || iss_y;
                tag_p0    <= tag_iss;
                vld_p1    <= vld_p0;
                tag_p1    <= tag_p0;
                vld_p2    <= vld_p1;
                tag_p2    <= tag_p1;
                out_valid <= vld_p2 && !tag_p2.is_y;
                out_eol   <= vld_p2 && !tag_p2.is_y && tag_p2.eol;
                out_eof   <= vld_p2 && !tag_p2.is_y && tag_p2.eof;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (state == IDLE && start) begin
            out_w_r <= cfg_out_w;
            out_h_r <= cfg_out_h;
            in_w_r  <= cfg_in_w;
            in_h_r  <= cfg_in_h;
            scl_x_r <= cfg_scl_x;
            scl_y_r <= cfg_scl_y;
        end
        if (mul_ce && vld_p2 && tag_p2.is_y) begin
            src_y_r  <= y_int;
            frac_y_r <= y_frac;
        end
        if (mul_ce && vld_p2 && !tag_p2.is_y) begin
            out_src_x  <= x_int;
            out_frac_x <= x_frac;
            out_src_y  <= src_y_r;
            out_frac_y <= frac_y_r;
        end
    end

    pp_coord_split #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_split_x (
        .prod      (mul_dout),
        .bound     (in_w_r),
        .int_part  (x_int),
        .frac_part (x_frac)
    );

    pp_coord_split #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_split_y (
        .prod      (mul_dout),
        .bound     (in_h_r),
        .int_part  (y_int),
        .frac_part (y_frac)
    );

endmodule
